// File: rtl/cnn_fmap_pingpong_capture.sv
// Two-bank feature-map capture: whole CO-channel frames are written into one bank
// while the other bank is available for random-access readback.

module cnn_fmap_lane #(
    parameter int DW    = 20,
    parameter int DEPTH = 576,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    // Sample storage is deliberately left unreset so it can map onto block RAM.
    logic [DW-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_bank][rd_addr];
    end
endmodule

module cnn_fmap_pingpong_capture #(
    parameter int CO      = 3,
    parameter int O_F_BW  = 20,
    parameter int OUT_W   = 24,
    parameter int OUT_H   = 24,
    parameter int FC_BW   = 16,
    localparam int DEPTH   = OUT_W * OUT_H,
    localparam int ADDR_BW = $clog2(DEPTH),
    localparam int CH_BW   = (CO > 1) ? $clog2(CO) : 1,
    localparam int XW      = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int YW      = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_in_valid,
    input  logic [CO*O_F_BW-1:0]   i_in_fmap,
    output logic                   o_in_ready,
    input  logic                   i_abort,
    input  logic                   i_rd_req,
    input  logic [CH_BW-1:0]       i_rd_ch,
    input  logic [ADDR_BW-1:0]     i_rd_addr,
    output logic                   o_rd_valid,
    output logic [O_F_BW-1:0]      o_rd_data,
    input  logic                   i_rd_release,
    output logic                   o_bank_ready,
    output logic                   o_rd_bank,
    output logic [XW-1:0]          o_x,
    output logic [YW-1:0]          o_y,
    output logic                   o_frame_done,
    output logic [FC_BW-1:0]       o_frame_cnt,
    output logic                   o_overflow,
    input  logic                   i_clr_ovf
);
    logic [1:0]                    bank_full, bank_full_nxt;
    logic                          wr_bank, rd_bank;
    logic [XW-1:0]                 x;
    logic [YW-1:0]                 y;
    logic [ADDR_BW-1:0]            wr_addr;
    logic                          frame_done, overflow, rd_vld;
    logic [FC_BW-1:0]              frame_cnt;
    logic [CH_BW-1:0]              rd_ch_q;
    logic [CO-1:0][O_F_BW-1:0]     in_fmap, lane_q;
    logic                          accept, drop, row_end, last_beat, release_fire, rd_fire;

    assign in_fmap      = i_in_fmap;
    assign accept       = i_in_valid && !bank_full[wr_bank] && !i_abort;
    assign drop         = i_in_valid && bank_full[wr_bank];
    assign row_end      = (x == XW'(OUT_W - 1));
    assign last_beat    = accept && row_end && (y == YW'(OUT_H - 1));
    assign release_fire = i_rd_release && bank_full[rd_bank];
    assign rd_fire      = i_rd_req && bank_full[rd_bank]
                          && ({1'b0, i_rd_ch} < (CH_BW + 1)'(CO))
                          && ({1'b0, i_rd_addr} < (ADDR_BW + 1)'(DEPTH));

    // Release and completion never collide on one bank: a full bank cannot be written.
    always_comb begin
        bank_full_nxt = bank_full;
        if (release_fire) bank_full_nxt[rd_bank] = 1'b0;
        if (last_beat)    bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_full  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            x          <= '0;
            y          <= '0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
            rd_vld     <= 1'b0;
            rd_ch_q    <= '0;
        end else begin
            frame_done <= last_beat;
            bank_full  <= bank_full_nxt;
            if (i_abort) begin
                x       <= '0;
                y       <= '0;
                wr_addr <= '0;
            end else if (accept) begin
                if (row_end) begin
                    x <= '0;
                    y <= (y == YW'(OUT_H - 1)) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                wr_addr <= last_beat ? '0 : wr_addr + 1'b1;
            end
            if (last_beat) begin
                wr_bank   <= ~wr_bank;
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (release_fire) rd_bank <= ~rd_bank;
            if (drop)           overflow <= 1'b1;
            else if (i_clr_ovf) overflow <= 1'b0;
            rd_vld <= rd_fire;
            if (rd_fire) rd_ch_q <= i_rd_ch;
        end
    end

    for (genvar ch = 0; ch < CO; ch++) begin : g_lane
        cnn_fmap_lane #(.DW(O_F_BW), .DEPTH(DEPTH), .AW(ADDR_BW)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (accept),
            .wr_bank (wr_bank),
            .wr_addr (wr_addr),
            .wr_data (in_fmap[ch]),
            .rd_en   (rd_fire),
            .rd_bank (rd_bank),
            .rd_addr (i_rd_addr),
            .rd_data (lane_q[ch])
        );
    end

    // Channel select is captured with the request so the output holds between reads.
    assign o_rd_data    = lane_q[rd_ch_q];
    assign o_rd_valid   = rd_vld;
    assign o_in_ready   = !bank_full[wr_bank];
    assign o_bank_ready = bank_full[rd_bank];
    assign o_rd_bank    = rd_bank;
    assign o_x          = x;
    assign o_y          = y;
    assign o_frame_done = frame_done;
    assign o_frame_cnt  = frame_cnt;
    assign o_overflow   = overflow;
endmodule

// File: tb/tb_cnn_fmap_pingpong_capture.sv
// Directed bench for the ping-pong capture stage; read data checked through a scoreboard queue.

module tb_cnn_fmap_pingpong_capture;
    localparam int CO = 3, O_F_BW = 20, OUT_W = 24, OUT_H = 24, FC_BW = 16;
    localparam int DEPTH = OUT_W * OUT_H;
    localparam int ADDR_BW = 10, CH_BW = 2, XW = 5, YW = 5;

    logic                 clk = 1'b0, reset = 1'b0;
    logic                 i_in_valid = 1'b0, i_abort = 1'b0, i_rd_req = 1'b0;
    logic                 i_rd_release = 1'b0, i_clr_ovf = 1'b0;
    logic [CO*O_F_BW-1:0] i_in_fmap = '0;
    logic [CH_BW-1:0]     i_rd_ch = '0;
    logic [ADDR_BW-1:0]   i_rd_addr = '0;
    logic                 o_in_ready, o_rd_valid, o_bank_ready, o_rd_bank;
    logic                 o_frame_done, o_overflow;
    logic [O_F_BW-1:0]    o_rd_data;
    logic [XW-1:0]        o_x;
    logic [YW-1:0]        o_y;
    logic [FC_BW-1:0]     o_frame_cnt;

    int tests = 0, fails = 0;
    logic [31:0] sb[$];

    cnn_fmap_pingpong_capture #(.CO(CO), .O_F_BW(O_F_BW), .OUT_W(OUT_W), .OUT_H(OUT_H), .FC_BW(FC_BW)) dut (
        .clk(clk), .reset(reset), .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap),
        .o_in_ready(o_in_ready), .i_abort(i_abort), .i_rd_req(i_rd_req), .i_rd_ch(i_rd_ch),
        .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .i_rd_release(i_rd_release), .o_bank_ready(o_bank_ready), .o_rd_bank(o_rd_bank),
        .o_x(o_x), .o_y(o_y), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
        .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [CO*O_F_BW-1:0] beat(input int base, input int addr);
        logic [CO*O_F_BW-1:0] r;
        r = '0;
        for (int ch = 0; ch < CO; ch++) r[ch*O_F_BW +: O_F_BW] = O_F_BW'(base + ch*1000 + addr);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input int base, input int addr);
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_fmap  = beat(base, addr);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic stream(input int base, input int n);
        for (int a = 0; a < n; a++) begin
            send_beat(base, a);
            chk("x", 32'(o_x), 32'(((a + 1) % DEPTH) % OUT_W));
            chk("y", 32'(o_y), 32'(((a + 1) % DEPTH) / OUT_W));
            chk("frame_done", 32'(o_frame_done), 32'(a == DEPTH - 1));
        end
    endtask

    task automatic rd(input int ch, input int addr, input logic rel, input logic exp_v, input int exp_d);
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_ch = CH_BW'(ch); i_rd_addr = ADDR_BW'(addr); i_rd_release = rel;
        if (exp_v) sb.push_back(32'(exp_d));
        @(posedge clk); #1;
        i_rd_req = 1'b0; i_rd_release = 1'b0;
        chk("rd_valid", 32'(o_rd_valid), 32'(exp_v));
        if (o_rd_valid && sb.size() > 0) chk("rd_data", 32'(o_rd_data), sb.pop_front());
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", 32'(o_in_ready), 1);
        chk("rst_bank_ready", 32'(o_bank_ready), 0);
        chk("rst_rd_bank", 32'(o_rd_bank), 0);
        chk("rst_x", 32'(o_x), 0);
        chk("rst_y", 32'(o_y), 0);
        chk("rst_frame_done", 32'(o_frame_done), 0);
        chk("rst_frame_cnt", 32'(o_frame_cnt), 0);
        chk("rst_overflow", 32'(o_overflow), 0);
        chk("rst_rd_valid", 32'(o_rd_valid), 0);
        chk("rst_rd_data", 32'(o_rd_data), 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2 chk_reset_state();
        @(negedge clk) reset = 1'b0;

        // Frame 1 into bank 0, then readback
        stream(0, DEPTH);
        chk("f1_cnt", 32'(o_frame_cnt), 1);
        chk("f1_bank_ready", 32'(o_bank_ready), 1);
        chk("f1_rd_bank", 32'(o_rd_bank), 0);
        chk("f1_in_ready", 32'(o_in_ready), 1);
        tick();
        chk("f1_done_single", 32'(o_frame_done), 0);
        rd(2, 25, 1'b0, 1'b1, 2025);
        tick();
        chk("rd_idle_valid", 32'(o_rd_valid), 0);
        chk("rd_idle_hold", 32'(o_rd_data), 2025);

        // Frame 2 into bank 1 fills both banks; further beats drop
        stream(0, DEPTH);
        chk("f2_cnt", 32'(o_frame_cnt), 2);
        chk("f2_in_ready", 32'(o_in_ready), 0);
        send_beat(0, 0);
        chk("drop_ovf", 32'(o_overflow), 1);
        chk("drop_x", 32'(o_x), 0);
        chk("drop_y", 32'(o_y), 0);
        chk("drop_cnt", 32'(o_frame_cnt), 2);
        i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
        chk("clr_ovf", 32'(o_overflow), 0);
        i_clr_ovf = 1'b1; send_beat(0, 1); i_clr_ovf = 1'b0;
        chk("set_beats_clr", 32'(o_overflow), 1);
        i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
        chk("clr_ovf2", 32'(o_overflow), 0);

        // Release bank 0, read bank 1, read+release together, then idle release
        i_rd_release = 1'b1; tick(); i_rd_release = 1'b0;
        chk("rel_rd_bank", 32'(o_rd_bank), 1);
        chk("rel_bank_ready", 32'(o_bank_ready), 1);
        chk("rel_in_ready", 32'(o_in_ready), 1);
        rd(0, 0, 1'b0, 1'b1, 0);
        rd(1, DEPTH - 1, 1'b1, 1'b1, 1000 + DEPTH - 1);
        chk("rdrel_rd_bank", 32'(o_rd_bank), 0);
        chk("rdrel_bank_ready", 32'(o_bank_ready), 0);
        i_rd_release = 1'b1; tick(); i_rd_release = 1'b0;
        chk("empty_rel_rd_bank", 32'(o_rd_bank), 0);
        chk("empty_rel_bank_ready", 32'(o_bank_ready), 0);
        rd(0, 0, 1'b0, 1'b0, 0);
        chk("noready_hold", 32'(o_rd_data), 1000 + DEPTH - 1);

        // Partial frame aborted, then a fresh frame into bank 0
        stream(300000, 100);
        i_abort = 1'b1; send_beat(300000, 100); i_abort = 1'b0;
        chk("abort_x", 32'(o_x), 0);
        chk("abort_y", 32'(o_y), 0);
        chk("abort_done", 32'(o_frame_done), 0);
        chk("abort_ovf", 32'(o_overflow), 0);
        chk("abort_cnt", 32'(o_frame_cnt), 2);
        chk("abort_bank_ready", 32'(o_bank_ready), 0);
        stream(500000, DEPTH);
        chk("f3_cnt", 32'(o_frame_cnt), 3);
        chk("f3_bank_ready", 32'(o_bank_ready), 1);
        for (int a = 0; a < 100; a++) rd(a % CO, a, 1'b0, 1'b1, 500000 + (a % CO)*1000 + a);

        // Out-of-range reads are refused
        rd(3, 0, 1'b0, 1'b0, 0);
        rd(0, DEPTH, 1'b0, 1'b0, 0);
        chk("oor_hold", 32'(o_rd_data), 500099);
        chk("sb_empty", 32'(sb.size()), 0);

        // Asynchronous reset mid-frame
        stream(100000, 300);
        #2 reset = 1'b1;
        #1 chk_reset_state();
        @(negedge clk) reset = 1'b0;
        tick();
        chk("post_rst_bank_ready", 32'(o_bank_ready), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cnn_fmap_pingpong_capture.md
Name: cnn_fmap_pingpong_capture

Overview:
- Parametrised feature-map capture stage that sits behind a conv core (e.g. cnn_core, stage2_conv).
- Stores complete CO-channel OUT_W x OUT_H frames into two alternating banks.
- Exposes a random-access readback port so downstream logic or a debug master can read one frame while the next is being written.
- Adds frame tracking, back-pressure indication, abort and overflow reporting.

Parameters:
CO, 3, number of channels packed in each input beat
O_F_BW, 20, bits per channel sample (stored raw, no sign conversion)
OUT_W, 24, frame width in samples
OUT_H, 24, frame height in samples
FC_BW, 16, width of the frame counter
(derived) ADDR_BW = clog2(OUT_W*OUT_H); CH_BW = max(1, clog2(CO))

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_in_valid  in  1  input beat strobe
i_in_fmap  in  CO*O_F_BW  channel ch in bits [ch*O_F_BW +: O_F_BW]
o_in_ready  out  1  current write bank free; combinational from registered state
i_abort  in  1  discard partial frame in write bank
i_rd_req  in  1  read request
i_rd_ch  in  CH_BW  read channel
i_rd_addr  in  ADDR_BW  read address, y*OUT_W+x
o_rd_valid  out  1  read data valid
o_rd_data  out  O_F_BW  read data
i_rd_release  in  1  free current read bank
o_bank_ready  out  1  read bank holds a complete frame
o_rd_bank  out  1  index of current read bank
o_x  out  clog2(OUT_W)  next write column
o_y  out  clog2(OUT_H)  next write row
o_frame_done  out  1  one-cycle pulse on frame completion
o_frame_cnt  out  FC_BW  completed frames, wraps modulo 2^FC_BW
o_overflow  out  1  sticky: beat dropped
i_clr_ovf  in  1  clear o_overflow

Behaviour:
- Reset (async, immediate):
  - bank_full[1:0]=0, wr_bank=0, rd_bank=0, x=y=0.
  - o_frame_done=0, o_frame_cnt=0, o_overflow=0, o_rd_valid=0, o_rd_data=0.
  - Hence o_in_ready=1, o_bank_ready=0.
  - Memory contents are not reset.
- Write accept:
  - Condition: i_in_valid && !bank_full[wr_bank] && !i_abort.
  - Writes all CO samples to bank wr_bank at addr y*OUT_W+x.
  - x increments; at x==OUT_W-1, x->0 and y++.
- Last beat (x==OUT_W-1, y==OUT_H-1):
  - x,y->0, bank_full[wr_bank]->1, wr_bank toggles, o_frame_cnt++.
  - o_frame_done=1 on the following cycle for exactly one cycle.
- Drop:
  - Condition: i_in_valid && bank_full[wr_bank].
  - Beat discarded, counters unchanged, o_overflow->1.
- i_clr_ovf clears o_overflow. Same-cycle set and clear: set wins.
- i_abort (synchronous):
  - x,y->0; beat on same cycle is discarded.
  - No frame_done is raised and bank_full is unchanged.
  - o_overflow is unaffected.
- o_bank_ready = bank_full[rd_bank].
- Read:
  - Accepted when i_rd_req && o_bank_ready && i_rd_ch<CO && i_rd_addr<OUT_W*OUT_H.
  - Next cycle: o_rd_valid=1 and o_rd_data = sample, 1-cycle latency.
  - Otherwise o_rd_valid=0 next cycle and o_rd_data holds its last value.
- Release:
  - When o_bank_ready, i_rd_release clears bank_full[rd_bank] and toggles rd_bank.
  - Ignored when !o_bank_ready.
- Simultaneous events:
  - Read and release in the same cycle: the read uses the pre-release bank and returns valid data.
  - Release and frame completion in the same cycle: both take effect. They always target different banks or a bank in a consistent state.
  - A write into a bank freed this cycle is not accepted until the next cycle, since o_in_ready uses registered bank_full.
- Ordering: frames are read in completion order. Two full banks are held until released.

Test Plan:
1. Reset, stream 576 beats, data ch = ch*1000+addr -> o_frame_done pulses one cycle after the 576th beat; o_frame_cnt=1, o_bank_ready=1, o_rd_bank=0. Read ch2 addr 25 -> o_rd_valid next cycle with o_rd_data=2025.
2. Beat index 23 accepted -> o_x=0, o_y=1 afterwards. Beat 575 -> o_x=0, o_y=0.
3. Stream a second frame without release -> bank1 full, o_frame_cnt=2, o_in_ready=0. Next beat dropped: o_overflow=1, o_x/o_y stay 0. Pulse i_clr_ovf -> o_overflow=0.
4. Release bank0 -> o_rd_bank=1, o_bank_ready=1, o_in_ready=1 next cycle. Read bank1 addr 0 ch0 -> 0. Release on an empty bank is ignored.
5. Accept 100 beats, assert i_abort -> o_x=o_y=0, no frame_done. Then 576 fresh beats -> frame_done after beat 576; readback shows fresh data at addr 0..99.
6. Assert reset asynchronously mid-frame (beat 300, between clock edges) -> all outputs at reset values immediately. Out-of-range read (ch=3 or addr=576) -> o_rd_valid stays 0.
